// File: rtl/alarme_pkg.sv
// Shared types and default timing for the siren/flasher pattern generator.
package alarme_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        OFF  = 2'd2,
        COOL = 2'd3
    } state_t;

    localparam int ON_CYCLES       = 4;
    localparam int OFF_CYCLES      = 4;
    localparam int MAX_BURSTS      = 3;
    localparam int COOLDOWN_CYCLES = 10;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/alarme_sirene_timer.sv
// Loadable down-counter shared by the ON, OFF and COOL phases; done marks the last clock of a phase.
module alarme_timer #(
    parameter int W = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);

    logic [W-1:0] cnt_reg;

    always_ff @(posedge clock) begin
        if (!reset) begin
            cnt_reg <= '0;
        end else if (load) begin
            cnt_reg <= load_val;
        end else if (cnt_reg != '0) begin
            cnt_reg <= cnt_reg - 1'b1;
        end
    end

    assign done = (cnt_reg == '0);

endmodule

// File: rtl/alarme_sirene.sv
// Turns the alarm level into ON/OFF siren bursts, caps the burst count and then forces a cooldown.
module alarme_sirene
    import alarme_pkg::*;
#(
    parameter int ON_CYCLES       = alarme_pkg::ON_CYCLES,
    parameter int OFF_CYCLES      = alarme_pkg::OFF_CYCLES,
    parameter int MAX_BURSTS      = alarme_pkg::MAX_BURSTS,
    parameter int COOLDOWN_CYCLES = alarme_pkg::COOLDOWN_CYCLES,
    localparam int NB_W           = $clog2(MAX_BURSTS + 1)
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            alarme,
    input  logic            ignicao,
    output logic            sirene,
    output logic            pisca,
    output logic            ativo,
    output logic [NB_W-1:0] n_bursts
);

    localparam int CNT_W = $clog2(max3(ON_CYCLES, OFF_CYCLES, COOLDOWN_CYCLES) + 1);

    // The timer is loaded with N-1 on entry so done falls on the phase's last clock.
    localparam logic [CNT_W-1:0] ON_LOAD   = CNT_W'(ON_CYCLES - 1);
    localparam logic [CNT_W-1:0] OFF_LOAD  = CNT_W'(OFF_CYCLES - 1);
    localparam logic [CNT_W-1:0] COOL_LOAD = CNT_W'(COOLDOWN_CYCLES - 1);
    localparam logic [NB_W-1:0]  NB_MAX    = NB_W'(MAX_BURSTS);

    state_t            state_reg, state_next;
    logic [NB_W-1:0]   nb_reg, nb_next;
    logic              sirene_reg, pisca_reg, ativo_reg;
    logic              timer_load, timer_done;
    logic [CNT_W-1:0]  timer_val;

    alarme_timer #(.W(CNT_W)) u_timer (
        .clock    (clock),
        .reset    (reset),
        .load     (timer_load),
        .load_val (timer_val),
        .done     (timer_done)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_reg  <= IDLE;
            nb_reg     <= '0;
            sirene_reg <= 1'b0;
            pisca_reg  <= 1'b0;
            ativo_reg  <= 1'b0;
        end else begin
            state_reg  <= state_next;
            nb_reg     <= nb_next;
            sirene_reg <= (state_next == ON);
            pisca_reg  <= (state_next == ON);
            ativo_reg  <= (state_next != IDLE);
        end
    end

    always_comb begin
        state_next = state_reg;
        nb_next    = nb_reg;
        if (ignicao) begin
            state_next = IDLE;
            nb_next    = '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (alarme) begin
                        state_next = ON;
                        nb_next    = '0;
                    end
                end
                ON: begin
                    if (timer_done) begin
                        state_next = OFF;
                        nb_next    = (nb_reg == NB_MAX) ? nb_reg : nb_reg + 1'b1;
                    end
                end
                OFF: begin
                    if (timer_done) begin
                        if (nb_reg == NB_MAX) begin
                            state_next = COOL;
                        end else if (alarme) begin
                            state_next = ON;
                        end else begin
                            state_next = IDLE;
                            nb_next    = '0;
                        end
                    end
                end
                COOL: begin
                    // alarme is deliberately not looked at until the cooldown expires
                    if (timer_done) begin
                        state_next = IDLE;
                        nb_next    = '0;
                    end
                end
                default: begin
                    state_next = IDLE;
                    nb_next    = '0;
                end
            endcase
        end
    end

    always_comb begin
        timer_load = (state_next != state_reg);
        timer_val  = '0;
        case (state_next)
            ON:      timer_val = ON_LOAD;
            OFF:     timer_val = OFF_LOAD;
            COOL:    timer_val = COOL_LOAD;
            default: timer_val = '0;
        endcase
    end

    assign sirene   = sirene_reg;
    assign pisca    = pisca_reg;
    assign ativo    = ativo_reg;
    assign n_bursts = nb_reg;

endmodule
